// File: rtl/fifo_burst_reader.sv
// Burst-forming read stage behind a show-ahead synchronous FIFO.
// It pops full bursts when enough words are queued, and short bursts on timeout or flush.
module fifo_burst_reader #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 4,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic [CNT_WIDTH-1:0] i_fifo_count,
  input  logic                 i_fifo_empty,
  input  logic [WIDTH-1:0]     i_fifo_data,
  output logic                 o_fifo_pop,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_sop,
  output logic                 o_eop,
  input  logic                 i_flush,
  output logic                 o_busy
);

  localparam int BEATS_W = $clog2(BURST_LEN + 1);
  localparam int TIMER_W = $clog2(TIMEOUT);
  localparam logic [BEATS_W-1:0]   FULL_BEATS = BEATS_W'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(BURST_LEN);
  localparam logic [TIMER_W-1:0]   TIMER_MAX  = TIMER_W'(TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t             state_r;
  logic [BEATS_W-1:0] beats_r;
  logic [TIMER_W-1:0] timer_r;
  logic               first_r;
  logic [WIDTH-1:0]   data_r;
  logic               valid_r;
  logic               sop_r;
  logic               eop_r;

  logic               pop_s;
  logic               full_s;
  logic               short_s;
  logic               last_s;
  logic [BEATS_W-1:0] short_beats_s;

  // Burst decision terms and the pop strobe, all from registered state plus FIFO flags.
  always_comb begin
    pop_s         = 1'b0;
    full_s        = 1'b0;
    short_s       = 1'b0;
    last_s        = 1'b0;
    short_beats_s = BEATS_W'(1);
    if (state_r == BURST) begin
      pop_s = ~i_fifo_empty & (~valid_r | i_ready);
    end else begin
      pop_s = 1'b0;
    end
    full_s  = (i_fifo_count >= FULL_CNT);
    short_s = ~i_fifo_empty & ((timer_r == TIMER_MAX) | i_flush);
    last_s  = (beats_r == BEATS_W'(1));
    // A non-empty FIFO reporting zero occupancy still yields a one-word burst.
    if (i_fifo_count == {CNT_WIDTH{1'b0}}) begin
      short_beats_s = BEATS_W'(1);
    end else begin
      short_beats_s = BEATS_W'(i_fifo_count);
    end
  end

  // Burst FSM with beat counter and idle-age timer.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
      beats_r <= {BEATS_W{1'b0}};
      timer_r <= {TIMER_W{1'b0}};
      first_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (full_s) begin
            state_r <= BURST;
            beats_r <= FULL_BEATS;
            timer_r <= {TIMER_W{1'b0}};
            first_r <= 1'b1;
          end else if (short_s) begin
            state_r <= BURST;
            beats_r <= short_beats_s;
            timer_r <= {TIMER_W{1'b0}};
            first_r <= 1'b1;
          end else if (i_fifo_empty) begin
            timer_r <= {TIMER_W{1'b0}};
          end else if (timer_r != TIMER_MAX) begin
            timer_r <= timer_r + TIMER_W'(1);
          end else begin
            timer_r <= timer_r;
          end
        end
        BURST: begin
          timer_r <= {TIMER_W{1'b0}};
          if (pop_s) begin
            first_r <= 1'b0;
            if (beats_r != {BEATS_W{1'b0}}) begin
              beats_r <= beats_r - BEATS_W'(1);
            end else begin
              beats_r <= beats_r;
            end
            if (last_s) begin
              state_r <= IDLE;
            end else begin
              state_r <= BURST;
            end
          end else begin
            state_r <= BURST;
          end
        end
        default: begin
          state_r <= IDLE;
          beats_r <= {BEATS_W{1'b0}};
          timer_r <= {TIMER_W{1'b0}};
          first_r <= 1'b0;
        end
      endcase
    end
  end

  // Output stage: reloads on every pop, otherwise holds until accepted.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      data_r  <= {WIDTH{1'b0}};
      valid_r <= 1'b0;
      sop_r   <= 1'b0;
      eop_r   <= 1'b0;
    end else if (pop_s) begin
      data_r  <= i_fifo_data;
      valid_r <= 1'b1;
      sop_r   <= first_r;
      eop_r   <= last_s;
    end else if (valid_r & i_ready) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign o_fifo_pop = pop_s;
  assign o_data     = data_r;
  assign o_valid    = valid_r;
  assign o_sop      = sop_r;
  assign o_eop      = eop_r;
  assign o_busy     = (state_r == BURST) | valid_r;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized and directed bench for fifo_burst_reader with an in-bench FIFO and reference model.
module tb_fifo_burst_reader;

  localparam int W  = 32;
  localparam int CW = 4;
  localparam int BL = 4;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cnt, cnt1;
  logic          empty, empty1;
  logic [W-1:0]  fdata, fdata1;
  logic          pop, pop1;
  logic [W-1:0]  odata, odata1;
  logic          ov, ov1, ready, sop, sop1, eop, eop1, flush, busy, busy1;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(W), .CNT_WIDTH(CW), .BURST_LEN(BL), .TIMEOUT(TO)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_fifo_count(cnt), .i_fifo_empty(empty),
    .i_fifo_data(fdata), .o_fifo_pop(pop), .o_data(odata), .o_valid(ov), .i_ready(ready),
    .o_sop(sop), .o_eop(eop), .i_flush(flush), .o_busy(busy)
  );

  fifo_burst_reader #(.WIDTH(W), .CNT_WIDTH(CW), .BURST_LEN(1), .TIMEOUT(4)) u_dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_fifo_count(cnt1), .i_fifo_empty(empty1),
    .i_fifo_data(fdata1), .o_fifo_pop(pop1), .o_data(odata1), .o_valid(ov1), .i_ready(1'b1),
    .o_sop(sop1), .o_eop(eop1), .i_flush(1'b0), .o_busy(busy1)
  );

  typedef struct {
    logic [31:0] d;
    bit          s;
    bit          e;
    int          c;
  } acc_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] fq[$];
  logic [31:0] fq1[$];
  logic [31:0] exp1_q[$];
  int          acc1 = 0;
  bit          pop_seen = 1'b0;
  bit          pop1_seen = 1'b0;
  int          pop_cyc[$];
  acc_t        acc_q[$];

  // Reference model state: burst in progress, words left, first-word flag, idle age, output register.
  bit          m_burst, m_first, m_ov, m_os, m_oe, exp_pop;
  int          m_left, m_age;
  logic [31:0] m_od;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive_fifo();
    cnt    = (fq.size() > 15) ? 4'd15 : 4'(fq.size());
    empty  = (fq.size() == 0);
    fdata  = (fq.size() == 0) ? 32'h0 : fq[0];
    cnt1   = (fq1.size() > 15) ? 4'd15 : 4'(fq1.size());
    empty1 = (fq1.size() == 0);
    fdata1 = (fq1.size() == 0) ? 32'h0 : fq1[0];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pop_seen && fq.size() > 0) void'(fq.pop_front());
    if (pop1_seen && fq1.size() > 0) void'(fq1.pop_front());
    pop_seen  = 1'b0;
    pop1_seen = 1'b0;
    drive_fifo();
  endtask

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(fq.size() == 0 && !ov && !busy) && n < 400);
    if (n >= 400) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    acc_q.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle comparison against the model, then model advance.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_burst = 0; m_first = 0; m_ov = 0; m_os = 0; m_oe = 0; m_left = 0; m_age = 0; m_od = 0;
      chk("rst_valid", {31'd0, ov}, 32'd0);
      chk("rst_pop", {31'd0, pop}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      pop_seen  = 1'b0;
      pop1_seen = 1'b0;
    end else begin
      exp_pop = m_burst && !empty && (!m_ov || ready);
      chk("pop", {31'd0, pop}, {31'd0, exp_pop});
      chk("valid", {31'd0, ov}, {31'd0, m_ov});
      chk("busy", {31'd0, busy}, {31'd0, (m_burst || m_ov)});
      chk("no_pop_stalled", {31'd0, (pop & ov & ~ready)}, 32'd0);
      if (m_ov) begin
        chk("data", odata, m_od);
        chk("sop", {31'd0, sop}, {31'd0, m_os});
        chk("eop", {31'd0, eop}, {31'd0, m_oe});
      end
      if (ov && ready) acc_q.push_back('{odata, sop, eop, cyc});
      if (exp_pop) pop_cyc.push_back(cyc);
      if (exp_pop) begin
        m_od = fdata; m_os = m_first; m_oe = (m_left == 1); m_ov = 1;
      end else if (m_ov && ready) begin
        m_ov = 0;
      end
      if (m_burst) begin
        m_age = 0;
        if (exp_pop) begin
          m_first = 0;
          m_left--;
          if (m_left == 0) m_burst = 0;
        end
      end else if (int'(cnt) >= BL) begin
        m_burst = 1; m_left = BL; m_first = 1; m_age = 0;
      end else if (!empty && (m_age == TO - 1 || flush)) begin
        m_burst = 1; m_left = (cnt == 0) ? 1 : int'(cnt); m_first = 1; m_age = 0;
      end else if (empty) begin
        m_age = 0;
      end else if (m_age < TO - 1) begin
        m_age++;
      end
      pop_seen  = pop;
      pop1_seen = pop1;
      if (ov1) begin
        chk("bl1_sop", {31'd0, sop1}, 32'd1);
        chk("bl1_eop", {31'd0, eop1}, 32'd1);
        if (exp1_q.size() == 0) chk("bl1_extra_word", 32'd1, 32'd0);
        else chk("bl1_data", odata1, exp1_q.pop_front());
        acc1++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int p, e, f, n, k;
    logic [31:0] base;
    rst_n = 1'b0; ready = 1'b1; flush = 1'b0;
    drive_fifo();
    #1;
    chk("reset_data", odata, 32'd0);
    chk("reset_valid", {31'd0, ov}, 32'd0);
    chk("reset_sop", {31'd0, sop}, 32'd0);
    chk("reset_eop", {31'd0, eop}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pop", {31'd0, pop}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Two back-to-back full bursts.
    clear_logs();
    for (int i = 0; i < 8; i++) push(32'h1000_0000 + i);
    p = cyc;
    wait_idle();
    chk("t1_count", acc_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_data", acc_q[i].d, 32'h1000_0000 + i);
      chk("t1_sop", {31'd0, acc_q[i].s}, {31'd0, (i % 4 == 0)});
      chk("t1_eop", {31'd0, acc_q[i].e}, {31'd0, (i % 4 == 3)});
    end
    chk("t1_latency", acc_q[0].c - p, 32'd2);
    chk("t1_inburst", acc_q[3].c - acc_q[0].c, 32'd3);
    chk("t1_gap", acc_q[4].c - acc_q[3].c, 32'd2);

    // Trickle traffic: timeout forces a two-word burst.
    clear_logs();
    push(32'h2000_0000); push(32'h2000_0001);
    e = cyc;
    wait_idle();
    chk("t2_first_pop", pop_cyc[0] - e, 32'd64);
    chk("t2_count", acc_q.size(), 32'd2);
    chk("t2_sop0", {31'd0, acc_q[0].s}, 32'd1);
    chk("t2_eop0", {31'd0, acc_q[0].e}, 32'd0);
    chk("t2_sop1", {31'd0, acc_q[1].s}, 32'd0);
    chk("t2_eop1", {31'd0, acc_q[1].e}, 32'd1);

    // Flush pulse sends three queued words, and the idle timer restarts.
    clear_logs();
    for (int i = 0; i < 3; i++) push(32'h3000_0000 + i);
    repeat (10) step();
    flush = 1'b1;
    f = cyc;
    step();
    flush = 1'b0;
    wait_idle();
    chk("t3_pop_after_flush", pop_cyc[0] - f, 32'd1);
    chk("t3_count", acc_q.size(), 32'd3);
    chk("t3_last_eop", {31'd0, acc_q[2].e}, 32'd1);
    clear_logs();
    push(32'h3100_0000);
    e = cyc;
    wait_idle();
    chk("t3_timer_restart", pop_cyc[0] - e, 32'd64);

    // Backpressure with ready pattern 1,0,0,1.
    clear_logs();
    for (int i = 0; i < 4; i++) push(32'h4000_0000 + i);
    k = 0; n = 0;
    while (!(fq.size() == 0 && !ov && !busy) && n < 200) begin
      ready = (k % 4 == 0) || (k % 4 == 3);
      k++; n++;
      step();
    end
    ready = 1'b1;
    chk("t4_count", acc_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t4_data", acc_q[i].d, 32'h4000_0000 + i);
    chk("t4_sop", {31'd0, acc_q[0].s}, 32'd1);
    chk("t4_eop", {31'd0, acc_q[3].e}, 32'd1);

    // Asynchronous reset after the second pop of a burst.
    clear_logs();
    for (int i = 0; i < 4; i++) push(32'h5000_0000 + i);
    n = 0;
    while (pop_cyc.size() < 2 && n < 50) begin
      step();
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("t5_data_zero", odata, 32'd0);
    chk("t5_valid_zero", {31'd0, ov}, 32'd0);
    chk("t5_sop_zero", {31'd0, sop}, 32'd0);
    chk("t5_eop_zero", {31'd0, eop}, 32'd0);
    chk("t5_busy_zero", {31'd0, busy}, 32'd0);
    chk("t5_pop_zero", {31'd0, pop}, 32'd0);
    chk("t5_fifo_left", fq.size(), 32'd2);
    step(); step();
    rst_n = 1'b1;
    clear_logs();
    wait_idle();
    chk("t5_count", acc_q.size(), 32'd2);
    chk("t5_data0", acc_q[0].d, 32'h5000_0002);
    chk("t5_data1", acc_q[1].d, 32'h5000_0003);
    chk("t5_sop", {31'd0, acc_q[0].s}, 32'd1);
    chk("t5_eop", {31'd0, acc_q[1].e}, 32'd1);

    // Single-word bursts.
    acc1 = 0;
    for (int i = 0; i < 5; i++) begin
      fq1.push_back(32'h6000_0000 + i);
      exp1_q.push_back(32'h6000_0000 + i);
    end
    drive_fifo();
    n = 0;
    while (!(fq1.size() == 0 && !ov1 && !busy1) && n < 100) begin
      step();
      n++;
    end
    chk("t6_count", acc1, 32'd5);

    // Random traffic: dense phase, then sparse phase that exercises timeouts and flushes.
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 2500; c++) begin
        step();
        ready = ($urandom_range(0, 3) != 0);
        flush = ($urandom_range(0, 15) == 0);
        if (fq.size() < 15 && $urandom_range(0, (ph == 0) ? 2 : 40) == 0) begin
          base = $urandom;
          push(base);
        end
      end
    end
    flush = 1'b0;
    ready = 1'b1;
    wait_idle();
    chk("end_fifo_drained", fq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side stage placed directly downstream of the team's synchronous FIFO. It watches the FIFO count and empty flag, pops words in bursts of `BURST_LEN`, and presents them on a registered valid/ready stream with start-of-burst and end-of-burst markers. If words sit in the FIFO for `TIMEOUT` cycles without reaching `BURST_LEN`, or when flush is requested, it sends a short burst. This bounds latency for trickle traffic.

## Interface
- `WIDTH`, 32: data word width.
- `CNT_WIDTH`, 4: width of the FIFO count input.
- `BURST_LEN`, 4: words per full burst. Legal range is 1 ≤ BURST_LEN < 2**CNT_WIDTH.
- `TIMEOUT`, 64: idle cycles with a non-empty FIFO before a partial burst is forced. Must be ≥ 2.

Ports:
- `i_clock`  in  1  sole clock; all state on the rising edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_fifo_count`  in  CNT_WIDTH  current FIFO occupancy.
- `i_fifo_empty`  in  1  FIFO empty flag.
- `i_fifo_data`  in  WIDTH  FIFO head word (show-ahead, valid while not empty).
- `o_fifo_pop`  out  1  pop strobe; combinational from state.
- `o_data`  out  WIDTH  registered output word.
- `o_valid`  out  1  `o_data` is valid.
- `i_ready`  in  1  downstream accepts when `o_valid & i_ready`.
- `o_sop`  out  1  `o_data` is the first word of a burst.
- `o_eop`  out  1  `o_data` is the last word of a burst.
- `i_flush`  in  1  level; forces a partial burst from IDLE when the FIFO is non-empty.
- `o_busy`  out  1  high while the state is BURST or `o_valid` is high.

## Operation
**States**
- IDLE:
  - Go to BURST with `beats = BURST_LEN` when `i_fifo_count ≥ BURST_LEN`.
  - Otherwise, if `~i_fifo_empty & (timer == TIMEOUT-1 | i_flush)`, go to BURST with `beats = min(i_fifo_count, BURST_LEN)`. `beats` is at least 1 here.
- BURST:
  - `o_fifo_pop = ~i_fifo_empty & (~o_valid | i_ready)`.
  - Each pop decrements `beats`.
  - The pop with `beats == 1` is the last pop; the next state is IDLE.

**Timer**
- Counts IDLE cycles while `~i_fifo_empty`.
- Clears when empty, in BURST, or on burst start.
- Width is $clog2(TIMEOUT). It saturates at TIMEOUT-1.

**Output register**
- On each pop: `o_data <= i_fifo_data`, `o_valid <= 1`.
- `o_sop <= (first pop of burst)`, `o_eop <= (beats == 1)`.
- Otherwise, on `o_valid & i_ready`, `o_valid <= 0`.
- `o_data`, `o_sop` and `o_eop` hold their value while `o_valid & ~i_ready` (no change until accepted).

**Boundary conditions**
- Pop and accept in the same cycle: the register reloads and `o_valid` stays 1. The stream runs at 1 word/cycle.
- FIFO goes empty mid-burst (only possible if another agent pops): pop stalls and the burst resumes when data returns. `beats` is not modified.
- `i_flush` in BURST: ignored.
- `i_flush` with an empty FIFO: no action.
- Count ≥ BURST_LEN together with the timeout or flush in the same cycle: a full burst is taken.
- Reset asserted mid-burst: all state clears immediately. The word in the output register is dropped. FIFO contents are untouched.

**Arithmetic**
- `beats` is $clog2(BURST_LEN+1) bits wide.
- `i_fifo_count` is compared unsigned.
- No counter wraps: `beats` stops at 0 and the timer saturates.

## Timing
**Reset values**
- State is IDLE; the timer and `beats` are 0.
- Outputs `o_valid`, `o_sop`, `o_eop`, `o_busy` and `o_fifo_pop` are 0; `o_data` is 0.

**Latency**
- IDLE decision in cycle T, then BURST in T+1.
- The first pop is in T+1 if the register is free. The first `o_valid` with `o_sop` is in T+2.
- With `i_ready` held high, a full burst pops in T+1..T+BURST_LEN. Output is valid T+2..T+BURST_LEN+1, with `o_eop` in the last of those cycles.
- The state returns to IDLE at T+BURST_LEN+1. The earliest next pop is T+BURST_LEN+2, giving one bubble cycle between back-to-back bursts.

**Timeout**
- FIFO goes non-empty in cycle E and stays below BURST_LEN: the decision is at E+TIMEOUT-1 and the first pop at E+TIMEOUT.

**Signal timing**
- `o_fifo_pop` is combinational from registered state and `i_ready`. It never depends combinationally on `i_fifo_data`.

## Test plan
- Reset, then 8 words pushed into the FIFO with `i_ready` = 1 and BURST_LEN = 4 → two bursts of 4. `o_sop` is on words 0 and 4, `o_eop` on words 3 and 7. There is a 1-cycle gap between bursts and data order is preserved.
- 2 words pushed, then no traffic, with TIMEOUT = 64 → no pop until E+64. Then a 2-word burst with `o_sop` on the first word and `o_eop` on the second.
- 3 words queued and `i_flush` pulsed at cycle 10 → the first pop at cycle 11. A 3-word burst is sent and the timer clears.
- Full burst with `i_ready` toggling 1,0,0,1,… → `o_data`/`o_sop`/`o_eop` are stable while stalled. No pop occurs while `o_valid & ~i_ready`. All 4 words are delivered exactly once.
- `i_reset_n` dropped after the second beat of a burst → all outputs are 0 in the same cycle with no clock edge needed. After release, the remaining 2 queued words follow the timeout path and go out as a 2-word burst.
- BURST_LEN = 1 → every word is output with `o_sop` and `o_eop` both high.
